// File: rtl/dsp_i2s_tx.sv
// dsp_i2s_tx: stereo I2S serializer for the DSP output path.
// One-entry pending buffer, BCLK/LRCK/SDATA generation, sticky status.
module dsp_i2s_tx #(
  parameter int SAMPLE_BITS  = 16,
  parameter int SLOT_BITS    = 16,
  parameter int CLK_DIV_HALF = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] sample_l,
  input  logic [SAMPLE_BITS-1:0] sample_r,
  input  logic                   sample_valid,
  input  logic                   enable,
  input  logic                   status_clear,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata,
  output logic                   frame_sync,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int DW = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int WW = 2 * SAMPLE_BITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_LIM = BW'(SLOT_BITS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            bclk_q, bclk_d;
  logic            lrck_q, lrck_d;
  logic            sdata_q, sdata_d;
  logic [WW-1:0]   shifter_q, shifter_d;
  logic [WW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            fsync_q, fsync_d;
  logic            underrun_q, underrun_d;
  logic            overrun_q, overrun_d;
  logic            load;
  logic            consume;

  // Stream bit at frame position idx: {L, pad, R, pad}, MSB first.
  // The frame word is held whole and indexed rather than shifted, so
  // the previous frame stays available for an underrun repeat.
  function automatic logic stream_bit(
    input logic [WW-1:0] w,
    input logic [BW-1:0] idx
  );
    logic                   right;
    logic [BW-1:0]          b;
    logic [SAMPLE_BITS-1:0] s;
    right = (idx >= SLOT_LIM);
    b     = right ? idx - SLOT_LIM : idx;
    s     = right ? w[SAMPLE_BITS-1:0] : w[WW-1:SAMPLE_BITS];
    stream_bit = 1'b0;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (int'(b) == i) stream_bit = s[SAMPLE_BITS-1-i];
    end
  endfunction

  // FSM next state, BCLK divider and bit timing.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    shifter_d = shifter_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrck_d  = 1'b0;
        sdata_d = 1'b0;
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
            lrck_d  = (bit_d >= SLOT_LIM);
            // one-BCLK data delay: new position k carries stream bit k-1
            sdata_d = stream_bit(shifter_q, bit_q);
            if (bit_q == BIT_LAST) begin
              if (enable) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                sdata_d = 1'b0;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load && pend_full_q) shifter_d = pend_q;
  end

  // Pending entry handoff and sticky status flags.
  always_comb begin
    consume     = load & pend_full_q;
    pend_d      = sample_valid ? {sample_l, sample_r} : pend_q;
    pend_full_d = sample_valid | (pend_full_q & ~consume);
    fsync_d     = consume;
    underrun_d  = (load & ~pend_full_q)
                | (underrun_q & ~status_clear);
    overrun_d   = (sample_valid & pend_full_q & ~consume)
                | (overrun_q & ~status_clear);
  end

  // Serializer and FSM registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      shifter_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      shifter_q <= shifter_d;
    end
  end

  // Pending buffer and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      fsync_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      fsync_q     <= fsync_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign frame_sync = fsync_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dsp_i2s_tx.sv
// tb_dsp_i2s_tx: directed vectors for the I2S serializer.
// Frames are rebuilt from SDATA sampled on BCLK rising edges.
module tb_dsp_i2s_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        enable = 1'b0;
  logic        status_clear = 1'b0;

  logic i2s_bclk, i2s_lrck, i2s_sdata;
  logic frame_sync, underrun, overrun;
  logic b2, l2, s2, fs2, ur2, or2;

  always #5 clock = ~clock;

  dsp_i2s_tx dut (
    .clock(clock), .reset(reset),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .enable(enable),
    .status_clear(status_clear),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .frame_sync(frame_sync),
    .underrun(underrun), .overrun(overrun)
  );

  dsp_i2s_tx #(.CLK_DIV_HALF(2)) dut2 (
    .clock(clock), .reset(reset),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .enable(enable),
    .status_clear(status_clear),
    .i2s_bclk(b2), .i2s_lrck(l2),
    .i2s_sdata(s2), .frame_sync(fs2),
    .underrun(ur2), .overrun(or2)
  );

  int n_tests = 0;
  int n_fail = 0;

  // receiver model state
  int          cyc = 0;
  int          fs_cnt = 0;
  int          bper = 0, b_last = 0, lper = 0, l_last = 0;
  int          bper2 = 0, b2_last = 0, lper2 = 0, l2_last = 0;
  int          n_rise = 0;
  logic        b_prev = 0, l_prev = 0, last_lrck = 1;
  logic        b2_prev = 0, l2_prev = 0;
  logic [31:0] hist = '0;
  logic [31:0] cap[$];

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        n_rise = 0; last_lrck = 1'b1;
        b_prev = 0; l_prev = 0; b2_prev = 0; l2_prev = 0;
      end else begin
        if (i2s_bclk && !b_prev) begin
          bper = cyc - b_last; b_last = cyc;
          hist = {hist[30:0], i2s_sdata};
          n_rise++;
          if (!i2s_lrck && last_lrck) begin
            if (n_rise == 32) cap.push_back(hist);
            n_rise = 0;
          end
          last_lrck = i2s_lrck;
        end
        b_prev = i2s_bclk;
        if (!i2s_lrck && l_prev) begin
          lper = cyc - l_last; l_last = cyc;
        end
        l_prev = i2s_lrck;
        if (frame_sync) fs_cnt++;
        if (b2 && !b2_prev) begin
          bper2 = cyc - b2_last; b2_last = cyc;
        end
        b2_prev = b2;
        if (!l2 && l2_prev) begin
          lper2 = cyc - l2_last; l2_last = cyc;
        end
        l2_prev = l2;
      end
    end
  end

  typedef struct {
    logic [15:0] l1, r1;
    logic        s1;
    logic [15:0] l2, r2;
    logic        s2;
    logic [31:0] exp_word;
    logic        exp_ur, exp_or;
    int          exp_fs;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    status_clear = 1'b1;
    tick(1);
    status_clear = 1'b0;
  endtask

  // returns at #1 after the edge where LRCK fell (the load edge)
  task automatic wait_fall(input string name);
    logic prev;
    logic hit;
    prev = i2s_lrck;
    hit  = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick(1);
      if (prev && !i2s_lrck) hit = 1'b1;
      prev = i2s_lrck;
    end
    chk({name, "_lrck_fall"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic chk_cap(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (cap.size() > 0) got = cap[cap.size()-1];
    chk(name, got, exp);
  endtask

  int   fs0;
  int   bad;
  logic [31:0] got_word;

  initial begin
    vt[0] = '{16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0,
              32'h8001_7FFE, 1'b1, 1'b0, 0};
    vt[1] = '{16'h1234, 16'h5678, 1'b1, 16'h9ABC, 16'hDEF0, 1'b1,
              32'h9ABC_DEF0, 1'b0, 1'b1, 1};
    vt[2] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0, 16'h0, 1'b0,
              32'hA5A5_5A5A, 1'b0, 1'b0, 1};
    vt[3] = '{16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0,
              32'hA5A5_5A5A, 1'b1, 1'b0, 0};
    vt[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0, 16'h0, 1'b0,
              32'h0000_FFFF, 1'b0, 1'b0, 1};
    vt[5] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0, 16'h0, 1'b0,
              32'h7FFF_8000, 1'b0, 1'b0, 1};

    // reset, then idle with enable low
    tick(3);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_sync, underrun, overrun}
          != 6'b0) bad++;
    end
    chk("idle_outputs_zero", bad, 0);

    // first sample before the first load
    strobe(16'h8001, 16'h7FFE);
    fs0 = fs_cnt;
    enable = 1'b1;
    wait_fall("first");
    tick(3);
    chk_cap("first_frame", 32'h8001_7FFE);
    chk("first_fsync_count", fs_cnt - fs0, 1);
    chk("first_bclk_period", bper, 2);
    chk("underrun_after_empty_load", {31'd0, underrun}, 1);

    // table: each vector spans two frames
    foreach (vt[v]) begin
      clear_pulse();
      chk($sformatf("v%0d_flags_cleared", v),
          {30'd0, underrun, overrun}, 0);
      tick(6);
      if (vt[v].s1) strobe(vt[v].l1, vt[v].r1); else tick(1);
      tick(10);
      if (vt[v].s2) strobe(vt[v].l2, vt[v].r2); else tick(1);
      fs0 = fs_cnt;
      wait_fall($sformatf("v%0d_load", v));
      tick(3);
      chk($sformatf("v%0d_underrun", v), {31'd0, underrun},
          {31'd0, vt[v].exp_ur});
      chk($sformatf("v%0d_overrun", v), {31'd0, overrun},
          {31'd0, vt[v].exp_or});
      chk($sformatf("v%0d_fsync", v), fs_cnt - fs0, vt[v].exp_fs);
      wait_fall($sformatf("v%0d_cap", v));
      tick(3);
      chk_cap($sformatf("v%0d_frame", v), vt[v].exp_word);
    end

    chk("lrck_period", lper, 64);
    chk("bclk_period", bper, 2);
    chk("div2_bclk_period", bper2, 4);
    chk("div2_lrck_period", lper2, 128);

    // strobe coincident with the load edge
    wait_fall("coin_start");
    clear_pulse();
    tick(4);
    strobe(16'h1111, 16'h2222);
    tick(57);
    fs0 = fs_cnt;
    sample_l = 16'h3333; sample_r = 16'h4444; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    chk("coin_load_edge", {30'd0, frame_sync, i2s_lrck}, 32'd2);
    tick(3);
    chk("coin_no_overrun", {31'd0, overrun}, 0);
    wait_fall("coin_f1");
    tick(3);
    chk_cap("coin_old_entry", 32'h1111_2222);
    chk("coin_fsync_count", fs_cnt - fs0, 2);
    wait_fall("coin_f2");
    tick(3);
    chk_cap("coin_new_entry", 32'h3333_4444);
    chk("coin_still_no_overrun", {31'd0, overrun}, 0);

    // set beats clear in the same cycle
    clear_pulse();
    strobe(16'hAAAA, 16'hBBBB);
    tick(2);
    status_clear = 1'b1;
    strobe(16'hCCCC, 16'hDDDD);
    status_clear = 1'b0;
    chk("overrun_set_wins", {31'd0, overrun}, 1);
    clear_pulse();
    chk("overrun_cleared", {30'd0, underrun, overrun}, 0);

    // enable low: frame completes, no load at the wrap
    enable = 1'b0;
    fs0 = fs_cnt;
    wait_fall("disable");
    tick(3);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if ({i2s_bclk, i2s_lrck, i2s_sdata} != 3'b0) bad++;
    end
    chk("disabled_quiet", bad, 0);
    chk("disabled_no_fsync", fs_cnt - fs0, 0);
    chk("disabled_no_underrun", {31'd0, underrun}, 0);

    // reset mid-frame
    enable = 1'b1;
    tick(8);
    strobe(16'h0F0F, 16'hF0F0);
    tick(1);
    strobe(16'h1E1E, 16'hE1E1);
    tick(5);
    chk("pre_reset_overrun", {31'd0, overrun}, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs",
        {26'd0, i2s_bclk, i2s_lrck, i2s_sdata,
         frame_sync, underrun, overrun}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    cap.delete();
    wait_fall("post_reset");
    tick(3);
    chk("post_reset_underrun", {31'd0, underrun}, 1);
    chk("post_reset_cap_count", cap.size(), 1);
    got_word = 'x;
    if (cap.size() > 0) got_word = cap[0];
    chk("post_reset_zero_frame", got_word, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
